// File: rtl/arythcrypto_pkg.sv
// Shared opcodes, command codes and PRESENT S-box helpers for the arythcrypto unit.
package arythcrypto_pkg;

  localparam logic [2:0] OP_ADD      = 3'd0;
  localparam logic [2:0] OP_SUB      = 3'd1;
  localparam logic [2:0] OP_XOR      = 3'd2;
  localparam logic [2:0] OP_ROTL     = 3'd3;
  localparam logic [2:0] OP_SBOX     = 3'd4;
  localparam logic [2:0] OP_INV_SBOX = 3'd5;
  localparam logic [2:0] OP_MUL      = 3'd6;
  localparam logic [2:0] OP_ROUND    = 3'd7;

  localparam logic [1:0] CMD_IDLE   = 2'd0;
  localparam logic [1:0] CMD_LOAD_A = 2'd1;
  localparam logic [1:0] CMD_LOAD_B = 2'd2;
  localparam logic [1:0] CMD_EXEC   = 2'd3;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/arythcrypto_if.sv
// TT-style pin bundle; the harness drives ui_in/uio_in, the unit drives the rest.
interface arythcrypto_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/arythcrypto_alu.sv
// Combinational arithmetic/cipher datapath. MUL only exists when ARYTHCRYPTO_MUL_EN is defined.
module arythcrypto_alu
  import arythcrypto_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] result_o,
  output logic       carry_o
);

  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] rot_dbl;
  logic [7:0]  mix;
  logic [7:0]  mix_sub;

  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  assign diff    = {1'b0, a_i} - {1'b0, b_i};
  // Rotate by shifting a doubled copy; the upper byte is the rotated value.
  assign rot_dbl = {a_i, a_i} << b_i[2:0];
  assign mix     = a_i ^ b_i;
  assign mix_sub = {sbox(mix[7:4]), sbox(mix[3:0])};

`ifdef ARYTHCRYPTO_MUL_EN
  logic [15:0] prod;
  assign prod = a_i * b_i;
`endif

  always_comb begin
    result_o = 8'h00;
    carry_o  = 1'b0;
    unique case (op_i)
      OP_ADD:      {carry_o, result_o} = sum;
      OP_SUB:      {carry_o, result_o} = diff;
      OP_XOR:      result_o = mix;
      OP_ROTL:     result_o = rot_dbl[15:8];
      OP_SBOX:     result_o = {sbox(a_i[7:4]), sbox(a_i[3:0])};
      OP_INV_SBOX: result_o = {inv_sbox(a_i[7:4]), inv_sbox(a_i[3:0])};
`ifdef ARYTHCRYPTO_MUL_EN
      OP_MUL: begin
        result_o = prod[7:0];
        carry_o  = |prod[15:8];
      end
`else
      OP_MUL:      result_o = 8'h00;
`endif
      OP_ROUND:    result_o = {mix_sub[6:0], mix_sub[7]};
    endcase
  end

endmodule

// File: rtl/arythcrypto.sv
// arythcrypto top: operand/result registers, command decode and pin mapping.
// Optional multiplier enabled by defining ARYTHCRYPTO_MUL_EN.
module arythcrypto
  import arythcrypto_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  arythcrypto_if.slave  bus
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] res_q, res_d;
  logic       valid_q, valid_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;

  logic [7:0] alu_res;
  logic       alu_carry;
  logic [1:0] cmd;
  logic       unused_uio;

  assign cmd        = bus.uio_in[4:3];
  assign unused_uio = ^bus.uio_in[7:5];

  arythcrypto_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (bus.uio_in[2:0]),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = valid_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (cmd)
      CMD_LOAD_A: begin
        a_d     = bus.ui_in;
        valid_d = 1'b0;
      end
      CMD_LOAD_B: begin
        b_d     = bus.ui_in;
        valid_d = 1'b0;
      end
      CMD_EXEC: begin
        res_d   = alu_res;
        carry_d = alu_carry;
        zero_d  = (alu_res == 8'h00);
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= 8'h00;
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.uo_out  = res_q;
  assign bus.uio_out = {valid_q, carry_q, zero_q, 5'b00000};
  assign bus.uio_oe  = 8'hE0;

endmodule

// File: tb/tb_arythcrypto.sv
// Self-checking bench for arythcrypto: directed vectors plus randomized traffic vs. a reference model.
module tb_arythcrypto;
  import arythcrypto_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  arythcrypto_if bus ();

  arythcrypto u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int SB[16]  = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  int ISB[16] = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};

  // Reference architectural state
  logic [7:0] m_a, m_b, m_res;
  logic       m_valid, m_carry, m_zero;

  function automatic void model_alu(input int op, input int a, input int b,
                                    output int r, output int c);
    int t, n;
    r = 0;
    c = 0;
    case (op)
      0: begin t = a + b; r = t % 256; c = (t > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a ^ b;
      3: begin n = b % 8; r = ((a << n) | (a >> (8 - n))) % 256; end
      4: r = SB[a / 16] * 16 + SB[a % 16];
      5: r = ISB[a / 16] * 16 + ISB[a % 16];
`ifdef ARYTHCRYPTO_MUL_EN
      6: begin t = a * b; r = t % 256; c = (t > 255) ? 1 : 0; end
`else
      6: r = 0;
`endif
      default: begin
        t = a ^ b;
        t = SB[t / 16] * 16 + SB[t % 16];
        r = ((t << 1) | (t >> 7)) % 256;
      end
    endcase
  endfunction

  // Drive one clock worth of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic rstn, input logic [1:0] cmd, input logic [2:0] op,
                      input logic [7:0] data);
    logic [2:0] junk;
    int r, c;
    junk       = 3'($urandom_range(7, 0));
    rst_n      = rstn;
    bus.ui_in  = data;
    bus.uio_in = {junk, cmd, op};
    if (!rstn) begin
      m_a = 0; m_b = 0; m_res = 0; m_valid = 0; m_carry = 0; m_zero = 0;
    end else if (cmd == 2'd1) begin
      m_a = data; m_valid = 0;
    end else if (cmd == 2'd2) begin
      m_b = data; m_valid = 0;
    end else if (cmd == 2'd3) begin
      model_alu(int'(op), int'(m_a), int'(m_b), r, c);
      m_res = 8'(r); m_carry = (c != 0); m_zero = (r == 0); m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    step(1'b1, CMD_LOAD_A, 3'($urandom_range(7, 0)), a);
    step(1'b1, CMD_LOAD_B, 3'($urandom_range(7, 0)), b);
    step(1'b1, CMD_EXEC, op, 8'($urandom_range(255, 0)));
  endtask

  task automatic test_reset();
    step(1'b0, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
    step(1'b0, CMD_EXEC, 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
    tests_run++;
    if (bus.uo_out !== 8'h00) begin
      tests_failed++; $display("FAIL reset_uo_out got %h want 00", bus.uo_out);
    end
    tests_run++;
    if (bus.uio_out !== 8'h00) begin
      tests_failed++; $display("FAIL reset_uio_out got %h want 00", bus.uio_out);
    end
    tests_run++;
    if (bus.uio_oe !== 8'hE0) begin
      tests_failed++; $display("FAIL reset_uio_oe got %h want e0", bus.uio_oe);
    end
    do_op(OP_XOR, 8'h55, 8'h11);
    tests_run++;
    if (bus.uo_out !== 8'h44 || bus.uio_out !== 8'h80) begin
      tests_failed++;
      $display("FAIL reset_then_xor got %h/%h want 44/80", bus.uo_out, bus.uio_out);
    end
  endtask

  task automatic test_add_sub();
    do_op(OP_ADD, 8'hF0, 8'h20);
    tests_run++;
    if (bus.uo_out !== 8'h10 || bus.uio_out !== 8'hC0) begin
      tests_failed++; $display("FAIL add_carry got %h/%h want 10/c0", bus.uo_out, bus.uio_out);
    end
    do_op(OP_SUB, 8'h05, 8'h06);
    tests_run++;
    if (bus.uo_out !== 8'hFF || bus.uio_out !== 8'hC0) begin
      tests_failed++; $display("FAIL sub_borrow got %h/%h want ff/c0", bus.uo_out, bus.uio_out);
    end
    do_op(OP_SUB, 8'h07, 8'h07);
    tests_run++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'hA0) begin
      tests_failed++; $display("FAIL sub_zero got %h/%h want 00/a0", bus.uo_out, bus.uio_out);
    end
  endtask

  task automatic test_xor_rotl();
    do_op(OP_XOR, 8'h3C, 8'hA5);
    tests_run++;
    if (bus.uo_out !== 8'h99 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL xor got %h/%h want 99/80", bus.uo_out, bus.uio_out);
    end
    do_op(OP_ROTL, 8'h81, 8'h01);
    tests_run++;
    if (bus.uo_out !== 8'h03 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL rotl1 got %h/%h want 03/80", bus.uo_out, bus.uio_out);
    end
    do_op(OP_ROTL, 8'h81, 8'h08);
    tests_run++;
    if (bus.uo_out !== 8'h81 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL rotl8 got %h/%h want 81/80", bus.uo_out, bus.uio_out);
    end
  endtask

  task automatic test_sbox();
    do_op(OP_SBOX, 8'h01, 8'h00);
    tests_run++;
    if (bus.uo_out !== 8'hC5 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL sbox got %h/%h want c5/80", bus.uo_out, bus.uio_out);
    end
    step(1'b1, CMD_LOAD_A, OP_ADD, 8'hC5);
    step(1'b1, CMD_EXEC, OP_INV_SBOX, 8'h00);
    tests_run++;
    if (bus.uo_out !== 8'h01 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL inv_sbox got %h/%h want 01/80", bus.uo_out, bus.uio_out);
    end
    do_op(OP_ROUND, 8'h00, 8'h00);
    tests_run++;
    if (bus.uo_out !== 8'h99 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL round got %h/%h want 99/80", bus.uo_out, bus.uio_out);
    end
  endtask

  task automatic test_mul();
`ifdef ARYTHCRYPTO_MUL_EN
    do_op(OP_MUL, 8'h10, 8'h10);
    tests_run++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'hE0) begin
      tests_failed++; $display("FAIL mul_ovf got %h/%h want 00/e0", bus.uo_out, bus.uio_out);
    end
    do_op(OP_MUL, 8'h0F, 8'h03);
    tests_run++;
    if (bus.uo_out !== 8'h2D || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL mul got %h/%h want 2d/80", bus.uo_out, bus.uio_out);
    end
`else
    do_op(OP_MUL, 8'h0F, 8'h03);
    tests_run++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'hA0) begin
      tests_failed++; $display("FAIL mul_off got %h/%h want 00/a0", bus.uo_out, bus.uio_out);
    end
`endif
  endtask

  task automatic test_valid_latency();
    do_op(OP_ADD, 8'h12, 8'h34);
    step(1'b1, CMD_LOAD_A, OP_ADD, 8'h01);
    tests_run++;
    if (bus.uo_out !== 8'h46 || bus.uio_out !== 8'h00) begin
      tests_failed++; $display("FAIL load_clears_valid got %h/%h want 46/00", bus.uo_out, bus.uio_out);
    end
    // New operand must be visible to an execute on the very next cycle, but not before the edge.
    bus.uio_in = {3'b000, CMD_EXEC, OP_ADD};
    #2;
    tests_run++;
    if (bus.uo_out !== 8'h46 || bus.uio_out[7] !== 1'b0) begin
      tests_failed++; $display("FAIL exec_latency got %h/%h want 46/0", bus.uo_out, bus.uio_out[7]);
    end
    step(1'b1, CMD_EXEC, OP_ADD, 8'hFF);
    tests_run++;
    if (bus.uo_out !== 8'h35 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL exec_new_operand got %h/%h want 35/80", bus.uo_out, bus.uio_out);
    end
    step(1'b1, CMD_EXEC, OP_ADD, 8'h00);
    tests_run++;
    if (bus.uo_out !== 8'h35 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL reexec_hold got %h/%h want 35/80", bus.uo_out, bus.uio_out);
    end
    step(1'b1, CMD_IDLE, OP_SUB, 8'hAA);
    tests_run++;
    if (bus.uo_out !== 8'h35 || bus.uio_out !== 8'h80) begin
      tests_failed++; $display("FAIL idle_hold got %h/%h want 35/80", bus.uo_out, bus.uio_out);
    end
    step(1'b0, CMD_EXEC, OP_XOR, 8'h77);
    tests_run++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00 || bus.uio_oe !== 8'hE0) begin
      tests_failed++;
      $display("FAIL reset_beats_exec got %h/%h/%h want 00/00/e0", bus.uo_out, bus.uio_out,
               bus.uio_oe);
    end
    step(1'b1, CMD_EXEC, OP_ADD, 8'h99);
    tests_run++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'hA0) begin
      tests_failed++; $display("FAIL operands_cleared got %h/%h want 00/a0", bus.uo_out, bus.uio_out);
    end
  endtask

  task automatic test_random();
    logic rstn;
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(24, 0) != 0);
      step(rstn, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
      tests_run++;
      if (bus.uo_out !== m_res || bus.uio_out !== {m_valid, m_carry, m_zero, 5'b00000}) begin
        tests_failed++;
        $display("FAIL random[%0d] got %h/%h want %h/%h", i, bus.uo_out, bus.uio_out, m_res,
                 {m_valid, m_carry, m_zero, 5'b00000});
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    m_a = 0; m_b = 0; m_res = 0; m_valid = 0; m_carry = 0; m_zero = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_add_sub();
    test_xor_rotl();
    test_sbox();
    test_mul();
    test_valid_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
